// File: rtl/uart_trx.sv
// UART transmitter and receiver sharing one clock but otherwise independent.
// TX serialises start/data/parity/stop bits from a handshaked input word.
// RX synchronises the line, samples mid-bit, and reports data plus error flags.
module uart_trx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  // Counter must reach the longest stop period (two bit times).
  localparam int unsigned CW = $clog2(2 * CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] StopLast = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DATA_BITS - 1);
  localparam bit            HasParity = (PARITY != 0);
  localparam bit            OddParity = (PARITY == 2);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;

  tx_state_e            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [IW-1:0]        tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;

  // TX FSM: every bit holds for a full bit time; tx and tx_ready are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (tx_valid) begin
            tx_shift_q <= tx_data;
            tx_par_q   <= (^tx_data) ^ OddParity;
            tx_cnt_q   <= '0;
            tx         <= 1'b0;
            tx_ready   <= 1'b0;
            tx_state_q <= TxStart;
          end
        end
        TxStart: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx         <= tx_shift_q[0];
            tx_state_q <= TxData;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TxData: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == IdxLast) begin
              if (HasParity) begin
                tx         <= tx_par_q;
                tx_state_q <= TxPar;
              end else begin
                tx         <= 1'b1;
                tx_state_q <= TxStop;
              end
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              tx_shift_q <= tx_shift_q >> 1;
              tx         <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TxPar: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_q   <= '0;
            tx         <= 1'b1;
            tx_state_q <= TxStop;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TxStop: begin
          if (tx_cnt_q == StopLast) begin
            tx_cnt_q   <= '0;
            tx_ready   <= 1'b1;
            tx_state_q <= TxIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          tx         <= 1'b1;
          tx_ready   <= 1'b1;
          tx_state_q <= TxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxPar, RxStop, RxWaitHigh
  } rx_state_e;

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  rx_state_e            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [IW-1:0]        rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX FSM: half-bit start qualification, then one mid-bit sample per bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q    <= RxIdle;
      rx_cnt_q      <= '0;
      rx_idx_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == IdxLast) begin
              rx_state_q <= HasParity ? RxPar : RxStop;
            end else begin
              rx_idx_q <= rx_idx_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxPar: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q      <= '0;
            rx_data       <= rx_shift_q;
            rx_valid      <= 1'b1;
            rx_parity_err <= HasParity && (((^rx_shift_q) ^ OddParity) != rx_par_q);
            rx_frame_err  <= !rx_sync_q;
            // A low stop bit may be a break; wait for the line to recover.
            rx_state_q    <= rx_sync_q ? RxIdle : RxWaitHigh;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxWaitHigh: begin
          if (rx_sync_q) begin
            rx_state_q <= RxIdle;
          end
        end
        default: begin
          rx_state_q <= RxIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// Bench for uart_trx: three instances (no/even/odd parity), each either looped
// back tx->rx or driven directly. Expected receptions go into per-instance
// queues and are checked as rx_valid pulses arrive.
module tb_uart_trx;

  localparam int unsigned CPB  = 16;
  localparam int          NDUT = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data  [NDUT];
  logic       tx_valid [NDUT];
  logic       lb       [NDUT];
  logic       rx_drv   [NDUT];
  logic       tx_ready_w [NDUT];
  logic       tx_w       [NDUT];
  logic [7:0] rx_data_w  [NDUT];
  logic       rx_valid_w [NDUT];
  logic       perr_w     [NDUT];
  logic       ferr_w     [NDUT];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_trx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8),
      .PARITY      (g),
      .STOP_BITS   (1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (tx_data[g]),
      .tx_valid     (tx_valid[g]),
      .tx_ready     (tx_ready_w[g]),
      .tx           (tx_w[g]),
      .rx           (lb[g] ? tx_w[g] : rx_drv[g]),
      .rx_data      (rx_data_w[g]),
      .rx_valid     (rx_valid_w[g]),
      .rx_parity_err(perr_w[g]),
      .rx_frame_err (ferr_w[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit pop_exp(input int g, output exp_t e);
    e = '0;
    if (qsize(g) == 0) return 1'b0;
    case (g)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return 1'b1;
  endfunction

  // Scoreboard: every rx_valid cycle consumes one expected frame.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rst === 1'b1 && rx_valid_w[g] === 1'b1) begin
        if (!pop_exp(g, mon_e)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_valid dut%0d: got data %0h expected no frame",
                   g, rx_data_w[g]);
        end else begin
          check($sformatf("rx_data dut%0d", g), 32'(rx_data_w[g]), 32'(mon_e.data));
          check($sformatf("rx_parity_err dut%0d", g), 32'(perr_w[g]), 32'(mon_e.perr));
          check($sformatf("rx_frame_err dut%0d", g), 32'(ferr_w[g]), 32'(mon_e.ferr));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int g, input int budget);
    int n = 0;
    while (qsize(g) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain dut%0d", g), 32'(qsize(g)), 32'd0);
  endtask

  // Hands one word to TX and watches the frame until tx_ready returns.
  // Index i counts cycles from the first start-bit cycle.
  task automatic send(input int g, input logic [7:0] d, input int probe_at,
                      output logic probed, output int low_run, output int ready_low);
    int n = 0;
    bit in_start = 1'b1;
    probed = 1'b0;
    while (tx_ready_w[g] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("tx_ready_before_send dut%0d", g), 32'(tx_ready_w[g]), 32'd1);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    @(negedge clk);
    tx_valid[g] = 1'b0;
    tx_data[g]  = ~d;
    low_run   = 0;
    ready_low = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == probe_at) probed = tx_w[g];
      if (in_start && tx_w[g] == 1'b0) low_run++;
      else in_start = 1'b0;
      if (tx_ready_w[g] == 1'b1) break;
      ready_low++;
      // Offer a word mid-frame; it must be ignored.
      if (i == 50) tx_valid[g] = 1'b1;
      if (i == 51) tx_valid[g] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input int g, input logic [7:0] d, input bit has_par,
                             input logic par, input logic stop);
    rx_drv[g] = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv[g] = d[i];
      tick(CPB);
    end
    if (has_par) begin
      rx_drv[g] = par;
      tick(CPB);
    end
    rx_drv[g] = stop;
    tick(CPB);
  endtask

  vec_t       vecs [7];
  logic [7:0] words [3];
  logic       probed;
  int         low_run;
  int         ready_low;
  int         acc;
  int         t;
  int         first_t;
  int         last_t;

  initial begin
    // Direct-drive frames into the even-parity instance.
    vecs[0] = '{data: 8'hA5, par: 1'b1, stop: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA5, par: 1'b0, stop: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h07, par: 1'b1, stop: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h07, par: 1'b0, stop: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h3C, par: 1'b0, stop: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'hFE, par: 1'b1, stop: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[6] = '{data: 8'h00, par: 1'b1, stop: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b1};
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;

    rst = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      tx_data[g]  = 8'h00;
      tx_valid[g] = 1'b0;
      lb[g]       = 1'b1;
      rx_drv[g]   = 1'b1;
    end
    tick(3);

    for (int g = 0; g < NDUT; g++) begin
      check("reset tx", 32'(tx_w[g]), 32'd1);
      check("reset tx_ready", 32'(tx_ready_w[g]), 32'd1);
      check("reset rx_data", 32'(rx_data_w[g]), 32'd0);
      check("reset rx_valid", 32'(rx_valid_w[g]), 32'd0);
      check("reset rx_parity_err", 32'(perr_w[g]), 32'd0);
      check("reset rx_frame_err", 32'(ferr_w[g]), 32'd0);
    end
    rst = 1'b1;
    tick(2);

    // Loopback 0x55, no parity: 16-cycle start bit, 160-cycle frame.
    push_exp(0, '{data: 8'h55, perr: 1'b0, ferr: 1'b0});
    send(0, 8'h55, -1, probed, low_run, ready_low);
    check("start_bit_len", 32'(low_run), 32'd16);
    check("frame_len", 32'(ready_low), 32'd160);
    wait_drain(0, 400);

    // Parity bit on the line for 0x07: even -> 1, odd -> 0.
    push_exp(1, '{data: 8'h07, perr: 1'b0, ferr: 1'b0});
    send(1, 8'h07, 152, probed, low_run, ready_low);
    check("even_parity_bit", 32'(probed), 32'd1);
    check("frame_len_parity", 32'(ready_low), 32'd176);
    wait_drain(1, 400);
    push_exp(2, '{data: 8'h07, perr: 1'b0, ferr: 1'b0});
    send(2, 8'h07, 152, probed, low_run, ready_low);
    check("odd_parity_bit", 32'(probed), 32'd0);
    wait_drain(2, 400);

    // Table of directly driven frames; error flags must hold afterwards.
    lb[1] = 1'b0;
    tick(4);
    for (int i = 0; i < 7; i++) begin
      push_exp(1, '{data: vecs[i].data, perr: vecs[i].exp_perr, ferr: vecs[i].exp_ferr});
      drive_frame(1, vecs[i].data, 1'b1, vecs[i].par, vecs[i].stop);
      rx_drv[1] = 1'b1;
      tick(CPB);
      wait_drain(1, 400);
      check($sformatf("perr_hold vec%0d", i), 32'(perr_w[1]), 32'(vecs[i].exp_perr));
      check($sformatf("ferr_hold vec%0d", i), 32'(ferr_w[1]), 32'(vecs[i].exp_ferr));
    end

    // Break: low stop bit then line held low; only one rx_valid allowed.
    lb[0] = 1'b0;
    tick(4);
    push_exp(0, '{data: 8'h3C, perr: 1'b0, ferr: 1'b1});
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(50);
    check("break_single_valid", 32'(qsize(0)), 32'd0);
    rx_drv[0] = 1'b1;
    tick(CPB);
    push_exp(0, '{data: 8'h81, perr: 1'b0, ferr: 1'b0});
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    wait_drain(0, 400);
    check("ferr_cleared", 32'(ferr_w[0]), 32'd0);

    // Four-cycle glitch must be rejected, then a normal frame must be received.
    rx_drv[0] = 1'b0;
    tick(4);
    rx_drv[0] = 1'b1;
    tick(3 * CPB);
    push_exp(0, '{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
    drive_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    wait_drain(0, 400);

    // Back-to-back loopback with tx_valid held high: one idle cycle per gap.
    lb[0] = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) push_exp(0, '{data: words[i], perr: 1'b0, ferr: 1'b0});
    acc = 0;
    t = 0;
    first_t = 0;
    last_t = 0;
    tx_data[0]  = words[0];
    tx_valid[0] = 1'b1;
    while (acc < 3 && t < 2000) begin
      if (tx_ready_w[0] == 1'b1) begin
        if (acc == 0) first_t = t;
        last_t = t;
        acc++;
        @(negedge clk);
        t++;
        if (acc < 3) tx_data[0] = words[acc];
        else tx_valid[0] = 1'b0;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    tx_valid[0] = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    check("b2b_spacing", 32'(last_t - first_t), 32'd322);
    wait_drain(0, 600);

    // Reset 70 cycles into a looped-back frame.
    while (tx_ready_w[0] !== 1'b1) @(negedge clk);
    tx_data[0]  = 8'h5A;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    tick(69);
    check("midframe_tx_busy", 32'(tx_ready_w[0]), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort tx", 32'(tx_w[0]), 32'd1);
    check("abort tx_ready", 32'(tx_ready_w[0]), 32'd1);
    check("abort rx_valid", 32'(rx_valid_w[0]), 32'd0);
    @(negedge clk);
    tick(3);
    rst = 1'b1;
    tick(5);
    push_exp(0, '{data: 8'h3E, perr: 1'b0, ferr: 1'b0});
    send(0, 8'h3E, -1, probed, low_run, ready_low);
    check("post_reset_frame_len", 32'(ready_low), 32'd160);
    wait_drain(0, 400);

    tick(2 * CPB);
    for (int g = 0; g < NDUT; g++) check($sformatf("final_queue dut%0d", g), 32'(qsize(g)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_trx.md
UART_TRX -- requirements
Module: uart_trx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per bit; legal values are even and at least 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range is 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0, selecting parity mode: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, giving stop bits transmitted; legal values are 1 and 2.
REQ-005 The block SHALL have these ports:
- clk  input  1 -- single clock; all logic on rising edge.
- rst  input  1 -- asynchronous, active-low reset.
- tx_data  input  DATA_BITS -- byte to transmit.
- tx_valid  input  1 -- tx_data is offered.
- tx_ready  output  1 -- transmitter accepts tx_data.
- tx  output  1 -- serial out, idle high.
- rx  input  1 -- serial in, asynchronous, idle high.
- rx_data  output  DATA_BITS -- last received word.
- rx_valid  output  1 -- one-cycle pulse per received frame.
- rx_parity_err  output  1 -- parity mismatch on last frame.
- rx_frame_err  output  1 -- stop bit sampled low on last frame.

Function
REQ-006 TX SHALL use FSM states IDLE, START, DATA, PAR, STOP, with each bit held exactly CLKS_PER_BIT cycles.
REQ-007 tx_ready SHALL be high only in IDLE; a transfer occurs on a cycle where tx_valid and tx_ready are both high, and tx_data is captured on that cycle.
REQ-008 The start bit (tx=0) SHALL begin on the cycle after acceptance; data SHALL be sent LSB first.
REQ-009 The PAR state SHALL be skipped when PARITY=0; the parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-010 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE with tx_ready high on the next cycle.
REQ-011 A frame SHALL last (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, and back-to-back transfers SHALL add no extra idle cycles beyond the one IDLE cycle.
REQ-012 tx_data and tx_valid changes while tx_ready is low SHALL have no effect on the frame in flight.
REQ-013 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all RX decisions use the synchronized value.
REQ-014 RX SHALL use FSM states IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-015 In IDLE, synchronized rx=0 SHALL enter START; after CLKS_PER_BIT/2 cycles rx is re-sampled, and if it is 1 the event is treated as a glitch and RX returns to IDLE with no output.
REQ-016 Data, parity and stop bits SHALL each be sampled once, CLKS_PER_BIT cycles after the previous sample (mid-bit), LSB first into rx_data.
REQ-017 At the first stop-bit sample, RX SHALL update rx_data, rx_parity_err and rx_frame_err and pulse rx_valid for exactly one cycle; a second stop bit SHALL NOT be checked.
REQ-018 rx_parity_err SHALL be 0 when PARITY=0.
REQ-019 The error flags SHALL hold their values until the next rx_valid.
REQ-020 On a frame error, rx_valid SHALL still pulse, and RX SHALL enter WAIT_HIGH, returning to IDLE only after synchronized rx=1, so that a break condition never retriggers reception.
REQ-021 After a good stop-bit sample, RX SHALL return to IDLE immediately, so the next start edge may arrive half a bit later.
REQ-022 TX and RX SHALL be fully independent and SHALL operate simultaneously.

Reset
REQ-023 While rst=0, the outputs SHALL be tx=1, tx_ready=1, rx_data=0, rx_valid=0, rx_parity_err=0 and rx_frame_err=0, with both FSMs in IDLE and all counters at 0.
REQ-024 Reset asserted mid-frame SHALL abort both frames immediately (asynchronously); tx=1 and no rx_valid SHALL be produced for the aborted frame.

Verification
REQ-025 Loopback (tx->rx), defaults, send 0x55: tx low for exactly 16 cycles at the start bit; frame is 160 cycles; rx_data=0x55 with rx_valid pulsed once and no errors.
REQ-026 PARITY=1, send 0x07: the parity bit on tx is 1; loopback gives rx_data=0x07 with rx_parity_err=0. With PARITY=2, the parity bit for 0x07 is 0.
REQ-027 PARITY=1, drive rx directly with 0xA5 and parity bit 1 (wrong): rx_valid pulses with rx_data=0xA5 and rx_parity_err=1.
REQ-028 Drive rx with 0x3C and stop bit 0, then hold rx low for 50 cycles: one rx_valid with rx_frame_err=1, and no further rx_valid until rx returns high and a new start bit arrives.
REQ-029 Drive a 4-cycle low glitch on rx: no rx_valid, and RX is back in IDLE; hold tx_valid high with 3 words (0x01, 0x02, 0x03): 3 accepts with tx never high between a stop bit and the next start bit beyond 1 cycle, and 3 correct receptions in order.
REQ-030 Assert rst at cycle 70 of a frame: tx=1 immediately, tx_ready=1, no rx_valid; the next frame after release completes correctly.
